// File: rtl/fixed_point_add_arbiter_pkg.sv
// Shared widths, FSM encodings and requester IDs for the shared fixed-point adder arbiter.
package fixed_point_add_arbiter_pkg;
    localparam int DEF_INTEGER_PART_WIDTH    = 8;
    localparam int DEF_FRACTIONAL_PART_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESPOND = 2'd2
    } state_e;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;
endpackage

// File: rtl/fixed_point_add_arbiter_add.sv
// Combinational saturating signed fixed-point adder (fixed_point_add).
module fixed_point_add #(
    parameter int INTEGER_PART_WIDTH    = 8,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    localparam int NUMBER_WIDTH         = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
    input  logic [NUMBER_WIDTH-1:0] a_i,
    input  logic [NUMBER_WIDTH-1:0] b_i,
    output logic [NUMBER_WIDTH-1:0] sum_o,
    output logic                    saturated_o
);
    localparam logic [NUMBER_WIDTH-1:0] MAX_VAL = {1'b0, {(NUMBER_WIDTH-1){1'b1}}};
    localparam logic [NUMBER_WIDTH-1:0] MIN_VAL = {1'b1, {(NUMBER_WIDTH-1){1'b0}}};

    logic [NUMBER_WIDTH-1:0] wrap_sum;

    always_comb begin
        wrap_sum    = a_i + b_i;
        // Overflow only possible when operand signs agree and the wrapped sign flips.
        saturated_o = (a_i[NUMBER_WIDTH-1] == b_i[NUMBER_WIDTH-1]) &&
                      (wrap_sum[NUMBER_WIDTH-1] != a_i[NUMBER_WIDTH-1]);
        if (saturated_o) sum_o = a_i[NUMBER_WIDTH-1] ? MIN_VAL : MAX_VAL;
        else             sum_o = wrap_sum;
    end
endmodule

// File: rtl/fixed_point_add_arbiter.sv
// Round-robin arbiter sharing one saturating adder between two requesters; one op in flight.
module fixed_point_add_arbiter
    import fixed_point_add_arbiter_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = DEF_INTEGER_PART_WIDTH,
    parameter int FRACTIONAL_PART_WIDTH = DEF_FRACTIONAL_PART_WIDTH,
    localparam int NUMBER_WIDTH         = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [NUMBER_WIDTH-1:0] req0_a,
    input  logic [NUMBER_WIDTH-1:0] req0_b,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [NUMBER_WIDTH-1:0] req1_a,
    input  logic [NUMBER_WIDTH-1:0] req1_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_id,
    output logic [NUMBER_WIDTH-1:0] resp_result,
    output logic                    resp_saturated
);
    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_id_q, resp_id_d;
    logic [NUMBER_WIDTH-1:0] resp_result_q, resp_result_d;
    logic                    resp_sat_q, resp_sat_d;
    logic [NUMBER_WIDTH-1:0] op_a_q, op_b_q;
    logic                    op_id_q;

    logic                    grant;
    logic                    accept;
    logic [NUMBER_WIDTH-1:0] add_sum;
    logic                    add_sat;

    fixed_point_add #(
        .INTEGER_PART_WIDTH   (INTEGER_PART_WIDTH),
        .FRACTIONAL_PART_WIDTH(FRACTIONAL_PART_WIDTH)
    ) u_add (
        .a_i        (op_a_q),
        .b_i        (op_b_q),
        .sum_o      (add_sum),
        .saturated_o(add_sat)
    );

    // Contention goes to whoever did not win last; otherwise the lone requester wins.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant_q;
        else                          grant = req1_valid ? REQ_ID1 : REQ_ID0;
        req0_ready = (state_q == IDLE) && (grant == REQ_ID0) && req0_valid;
        req1_ready = (state_q == IDLE) && (grant == REQ_ID1) && req1_valid;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_sat_d    = resp_sat_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = grant;
                    state_d      = COMPUTE;
                end
            end
            COMPUTE: begin
                resp_result_d = add_sum;
                resp_sat_d    = add_sat;
                resp_id_d     = op_id_q;
                resp_valid_d  = 1'b1;
                state_d       = RESPOND;
            end
            RESPOND: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= REQ_ID1;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_sat_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_sat_q    <= resp_sat_d;
        end
    end

    // Operands carry no reset; they are only consumed after a handshake loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a_q  <= grant ? req1_a : req0_a;
            op_b_q  <= grant ? req1_b : req0_b;
            op_id_q <= grant;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_result    = resp_result_q;
    assign resp_saturated = resp_sat_q;
endmodule

// File: tb/tb_fixed_point_add_arbiter.sv
// Directed bench for the shared saturating adder arbiter.
module tb_fixed_point_add_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         resp_valid, resp_id, resp_saturated;
    logic         resp_ready = 1'b1;
    logic [W-1:0] resp_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fixed_point_add_arbiter #(.INTEGER_PART_WIDTH(8), .FRACTIONAL_PART_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_saturated(resp_saturated)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_sat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the COMPUTE cycle.
    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 0;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; end
        for (int i = 0; i < 10; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("handshake_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
    endtask

    int g_id[8], g_cyc[8], ng;
    int r_id[8], r_res[8], r_cyc[8], nr;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 16'h0300, 16'h0400, 16'h0700, 1'b0};
        vecs[1] = '{1'b1, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1};
        vecs[2] = '{1'b0, 16'h8000, 16'hFF00, 16'h8000, 1'b1};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h8000, 16'hFFFF, 1'b0};
        vecs[4] = '{1'b1, 16'h0180, 16'h0080, 16'h0200, 1'b0};
        vecs[5] = '{1'b1, 16'hFF00, 16'hFE80, 16'hFD80, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_resp_sat", resp_saturated, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].id, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_compute_novalid", i), resp_valid, 0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), resp_valid, 1);
            chk($sformatf("v%0d_id", i), resp_id, vecs[i].id);
            chk($sformatf("v%0d_result", i), resp_result, vecs[i].exp_res);
            chk($sformatf("v%0d_sat", i), resp_saturated, vecs[i].exp_sat);
            @(negedge clk);
            chk($sformatf("v%0d_valid_drop", i), resp_valid, 0);
        end

        // Contention, last_grant currently 1.
        req0_a = 16'h0100; req0_b = 16'h0200;
        req1_a = 16'h1000; req1_b = 16'h2000;
        req0_valid = 1; req1_valid = 1;
        ng = 0; nr = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready && req1_ready) chk("both_ready", 1, 0);
            if ((req0_ready || req1_ready) && ng < 8) begin
                g_id[ng] = req1_ready ? 1 : 0; g_cyc[ng] = c; ng++;
            end
            if (resp_valid && nr < 8) begin
                r_id[nr] = resp_id; r_res[nr] = resp_result; r_cyc[nr] = c; nr++;
            end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        chk("cont_grants", ng, 4);
        chk("cont_resps", nr, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cont_grant%0d", k), g_id[k], k % 2);
            chk($sformatf("cont_cyc%0d", k), g_cyc[k], 3 * k);
            chk($sformatf("cont_rid%0d", k), r_id[k], k % 2);
            chk($sformatf("cont_rres%0d", k), r_res[k], (k % 2) ? 32'h3000 : 32'h0300);
            chk($sformatf("cont_rcyc%0d", k), r_cyc[k], 3 * k + 2);
        end

        // Requester 0 drops valid before a handshake: last_grant must stay 1.
        req0_valid = 1;
        #1 chk("drop_ready_seen", req0_ready, 1);
        #1 req0_valid = 0;
        @(negedge clk);
        #1 chk("drop_no_transfer", resp_valid, 0);
        req0_valid = 1; req1_valid = 1;
        #1 chk("drop_grant0", req0_ready, 1);
        chk("drop_grant0_r1", req1_ready, 0);
        #1 req0_valid = 0; req1_valid = 0;
        @(negedge clk);

        // Backpressure in RESPOND.
        resp_ready = 0;
        issue(0, 16'h0300, 16'h0400);
        @(negedge clk);
        req0_a = 16'h0001; req0_b = 16'h0001;
        req1_a = 16'h0010; req1_b = 16'h0020;
        req0_valid = 1; req1_valid = 1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_valid%0d", c), resp_valid, 1);
            chk($sformatf("bp_result%0d", c), resp_result, 16'h0700);
            chk($sformatf("bp_id%0d", c), resp_id, 0);
            chk($sformatf("bp_r0rdy%0d", c), req0_ready, 0);
            chk($sformatf("bp_r1rdy%0d", c), req1_ready, 0);
            @(negedge clk);
        end
        resp_ready = 1;
        @(negedge clk);
        #1;
        chk("bp_after_valid", resp_valid, 0);
        chk("bp_after_r1rdy", req1_ready, 1);
        chk("bp_after_r0rdy", req0_ready, 0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk("bp_next_valid", resp_valid, 1);
        chk("bp_next_id", resp_id, 1);
        chk("bp_next_result", resp_result, 16'h0030);
        @(negedge clk);

        // Reset during COMPUTE discards the transaction.
        issue(1, 16'h0100, 16'h0100);
        rst_n = 0;
        #1;
        chk("rc_valid", resp_valid, 0);
        chk("rc_result", resp_result, 0);
        chk("rc_id", resp_id, 0);
        chk("rc_sat", resp_saturated, 0);
        chk("rc_r1rdy", req1_ready, 0);
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("rc_quiet%0d", c), resp_valid, 0);
            @(negedge clk);
        end
        req0_a = 16'h0005; req0_b = 16'h0006;
        req1_a = 16'h0007; req1_b = 16'h0008;
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rc_first_r0", req0_ready, 1);
        chk("rc_first_r1", req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk("rc_resp_valid", resp_valid, 1);
        chk("rc_resp_id", resp_id, 0);
        chk("rc_resp_result", resp_result, 16'h000B);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
